rtc_bus_ctrl: RTL
=================

Name: rtc_bus_ctrl

Overview:
- Sequencer for the external RTC's multiplexed address/data parallel bus.
- Sits directly upstream of the 2:1 output mux. It drives the mux select pair (ch0_mux2, ch1_mux2) and the mux data inputs: address on ch0, write data on ch1.
- Runs one complete read or write transaction per start request: address phase, gap, data phase, gap, then a done pulse.
- Owns the bus strobes and output enable, and captures read data from the bus.

Parameters:
- T_ADDR, 4, address-phase length in clk cycles (>=1)
- T_GAP, 2, idle gap after each phase in clk cycles (>=1)
- T_DATA, 4, data-phase length in clk cycles (>=1)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  transaction request, sampled only in IDLE
- rw  in  1  1=write, 0=read; latched with start
- addr  in  8  register address; latched with start
- wdata  in  8  write data; latched with start
- bus_in  in  8  bus value read back from the pads
- ch0_data  out  8  latched address, feeds mux ch0
- ch1_data  out  8  latched write data, feeds mux ch1
- ch0_mux2  out  1  mux control bit 0
- ch1_mux2  out  1  mux control bit 1
- out_en  out  1  pad drive enable, 1=drive bus with mux output
- cs_n  out  1  chip select, active low
- ad_n  out  1  address strobe, active low
- wr_n  out  1  write strobe, active low
- rd_n  out  1  read strobe, active low
- rdata  out  8  captured read data
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; cs_n, ad_n, wr_n, rd_n = 1; out_en, ch0_mux2, ch1_mux2, busy, done = 0; rdata, ch0_data, ch1_data = 0x00.
- States: IDLE -> ADDR -> AGAP -> DATA -> DGAP -> DONE -> IDLE. An 8-bit down-counter times each phase.
- IDLE: if start=1 at an edge, latch addr->ch0_data, wdata->ch1_data and rw, then go to ADDR. start is ignored in every other state; there is no queuing.
- ADDR (T_ADDR cycles): cs_n=0, ad_n=0, out_en=1, ch0_mux2=1, ch1_mux2=0, so the mux outputs the address.
- AGAP and DGAP (T_GAP cycles each): all strobes high, out_en=0, ch0_mux2=0, ch1_mux2=0.
- DATA, write (T_DATA cycles): cs_n=0, wr_n=0, out_en=1, ch0_mux2=1, ch1_mux2=1, so the mux outputs the write data.
- DATA, read (T_DATA cycles): cs_n=0, rd_n=0, out_en=0, ch0_mux2=0, ch1_mux2=0. rdata captures bus_in at the clock edge that ends the last DATA cycle.
- rdata is held until the next read completes. Writes never modify rdata.
- wr_n and rd_n are never low simultaneously. out_en is never 1 during a read data phase.
- DONE: one cycle with done=1 and busy=1, strobes high; then IDLE.
- busy falls to 0 in the cycle after DONE. A new start is accepted on that first IDLE edge.
- Timing, defaults, start sampled at edge k:
  - ADDR = cycles k+1..k+4
  - AGAP = k+5..k+6
  - DATA = k+7..k+10
  - DGAP = k+11..k+12
  - DONE = k+13
  - Total = T_ADDR + 2*T_GAP + T_DATA + 1 cycles.
- Reset asserted mid-transaction: outputs go to their reset values immediately (asynchronous), the transaction is abandoned and no done pulse is issued. After reset release, the block waits in IDLE for a new start.
- start held high continuously: a new transaction starts on each return to IDLE, back-to-back, separated by exactly one IDLE cycle.
- Input changes on addr, wdata or rw while busy have no effect on the transaction in progress.

Test Plan:
- Reset check: hold reset=0, toggle clk -> all strobes 1, out_en=0, busy=0, rdata=0x00. Release reset -> outputs remain idle.
- Write: start=1, rw=1, addr=0x21, wdata=0x59 for one cycle -> ch0_data=0x21, ch1_data=0x59. ad_n=0 and sel pair=10 for 4 cycles, then 2 idle cycles. wr_n=0, out_en=1 and sel pair=11 for 4 cycles, then 2 idle cycles. done=1 at k+13 only.
- Read: rw=0, addr=0x24, bus_in=0xA7 during DATA -> rd_n=0 for 4 cycles with out_en=0 throughout DATA; rdata=0xA7 by k+11; done at k+13. A following write leaves rdata=0xA7.
- Busy ignore: pulse start again at k+5 with addr=0x10 -> no effect; ch0_data stays 0x21; exactly one done.
- Reset mid-op: drop reset during DATA of a write -> wr_n=1 and out_en=0 immediately; no done. After release, a fresh read completes normally.
- Back-to-back: start held high with T_ADDR=1, T_GAP=1, T_DATA=1 -> done every 6 cycles with a single IDLE cycle between transactions.

Source files
------------

// File: rtl/rtc_bus_ctrl.sv
// Transaction sequencer for the RTC multiplexed address/data bus.
// Drives mux selects, strobes and pad enable; captures read data.
module rtc_bus_ctrl #(
  parameter int unsigned T_ADDR = 4,
  parameter int unsigned T_GAP  = 2,
  parameter int unsigned T_DATA = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] bus_in,
  output logic [7:0] ch0_data,
  output logic [7:0] ch1_data,
  output logic       ch0_mux2,
  output logic       ch1_mux2,
  output logic       out_en,
  output logic       cs_n,
  output logic       ad_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_AGAP, S_DATA, S_DGAP, S_DONE
  } state_e;

  localparam logic [7:0] CNT_A = 8'(T_ADDR - 1);
  localparam logic [7:0] CNT_G = 8'(T_GAP - 1);
  localparam logic [7:0] CNT_D = 8'(T_DATA - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rw_q, rw_d;
  logic [7:0] ch0_q, ch0_d;
  logic [7:0] ch1_q, ch1_d;
  logic [7:0] rdata_q, rdata_d;
  logic       cs_n_q, cs_n_d;
  logic       ad_n_q, ad_n_d;
  logic       wr_n_q, wr_n_d;
  logic       rd_n_q, rd_n_d;
  logic       oe_q, oe_d;
  logic       m0_q, m0_d;
  logic       m1_q, m1_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       cnt_end;
  assign cnt_end = (cnt_q == 8'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    ch0_d   = ch0_q;
    ch1_d   = ch1_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ADDR;
          cnt_d   = CNT_A;
          rw_d    = rw;
          ch0_d   = addr;
          ch1_d   = wdata;
        end
      end
      S_ADDR: begin
        if (cnt_end) begin
          state_d = S_AGAP;
          cnt_d   = CNT_G;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_AGAP: begin
        if (cnt_end) begin
          state_d = S_DATA;
          cnt_d   = CNT_D;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DATA: begin
        if (cnt_end) begin
          state_d = S_DGAP;
          cnt_d   = CNT_G;
          // sample on the edge closing the last read-strobe cycle
          if (!rw_q) rdata_d = bus_in;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DGAP: begin
        if (cnt_end) begin
          state_d = S_DONE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // outputs are decoded from the next state so they register with it
  always_comb begin
    cs_n_d = 1'b1;
    ad_n_d = 1'b1;
    wr_n_d = 1'b1;
    rd_n_d = 1'b1;
    oe_d   = 1'b0;
    m0_d   = 1'b0;
    m1_d   = 1'b0;
    done_d = 1'b0;
    busy_d = (state_d != S_IDLE);
    unique case (state_d)
      S_ADDR: begin
        cs_n_d = 1'b0;
        ad_n_d = 1'b0;
        oe_d   = 1'b1;
        m0_d   = 1'b1;
      end
      S_DATA: begin
        cs_n_d = 1'b0;
        if (rw_d) begin
          wr_n_d = 1'b0;
          oe_d   = 1'b1;
          m0_d   = 1'b1;
          m1_d   = 1'b1;
        end else begin
          rd_n_d = 1'b0;
        end
      end
      S_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      rw_q    <= 1'b0;
      ch0_q   <= 8'h00;
      ch1_q   <= 8'h00;
      rdata_q <= 8'h00;
      cs_n_q  <= 1'b1;
      ad_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      m0_q    <= 1'b0;
      m1_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      ch0_q   <= ch0_d;
      ch1_q   <= ch1_d;
      rdata_q <= rdata_d;
      cs_n_q  <= cs_n_d;
      ad_n_q  <= ad_n_d;
      wr_n_q  <= wr_n_d;
      rd_n_q  <= rd_n_d;
      oe_q    <= oe_d;
      m0_q    <= m0_d;
      m1_q    <= m1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ch0_data = ch0_q;
  assign ch1_data = ch1_q;
  assign ch0_mux2 = m0_q;
  assign ch1_mux2 = m1_q;
  assign out_en   = oe_q;
  assign cs_n     = cs_n_q;
  assign ad_n     = ad_n_q;
  assign wr_n     = wr_n_q;
  assign rd_n     = rd_n_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
